// File: rtl/rib_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rib_rr_arbiter_pkg
// Description : Shared constants and state encoding for the RIB round-robin
//               arbiter (grant width, master indices, FSM states).
// Revision    : 1.0 - initial release
// ============================================================================
package rib_rr_arbiter_pkg;

    // Grant index width for the four-master RIB bus
    localparam int RIB_GW       = 2;

    // Master slot assignment on the RIB bus
    localparam int RIB_M_CORE_D = 0;
    localparam int RIB_M_CORE_I = 1;
    localparam int RIB_M_DMA    = 2;
    localparam int RIB_M_DBG    = 3;

    // Arbiter states, one-bit encoding
    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

endpackage : rib_rr_arbiter_pkg
`default_nettype wire

// File: rtl/rib_rr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rib_rr_arbiter_rr_pick
// Description : Combinational rotating-priority picker (rr_pick). Returns the
//               first requesting index after i_last, wrapping, optionally
//               skipping i_mask_idx.
// Revision    : 1.0 - initial release
// ============================================================================
module rib_rr_arbiter_rr_pick #(
    parameter int NUM_MASTERS = 4,
    parameter int GW          = 2
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [GW-1:0]          i_last,
    input  logic [GW-1:0]          i_mask_idx,
    input  logic                   i_mask_en,
    output logic [GW-1:0]          o_idx,
    output logic                   o_valid
);

    int w_pos;

    // Scan from the farthest offset back to the nearest so the nearest
    // eligible requester after i_last is the final (winning) assignment.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        w_pos   = 0;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            w_pos = (int'(i_last) + i) % NUM_MASTERS;
            if (i_req[w_pos] && !(i_mask_en && (i_mask_idx == GW'(w_pos)))) begin
                o_idx   = GW'(w_pos);
                o_valid = 1'b1;
            end
        end
    end

endmodule : rib_rr_arbiter_rr_pick
`default_nettype wire

// File: rtl/rib_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rib_rr_arbiter
// Description : Registered round-robin arbiter for the RIB bus with grant
//               holding, hold-time limit and timeout preemption. Drives the
//               bus mux select and the core pipeline stall flag.
//               Optional macro RIB_ARB_DEBUG_PRIO_EN: the top master (debug)
//               overrides rotation and preempts non-locked owners at once.
// Revision    : 1.0 - initial release
// ============================================================================
module rib_rr_arbiter
    import rib_rr_arbiter_pkg::*;
#(
    parameter int  NUM_MASTERS = 4,
    parameter int  GW          = RIB_GW,
    parameter int  MAX_HOLD    = 16,
    parameter int  CORE_MASTER = RIB_M_CORE_I,
    localparam int CW          = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [NUM_MASTERS-1:0] lock_i,
    output logic [GW-1:0]          grant_o,
    output logic                   grant_valid_o,
    output logic                   hold_flag_o,
    output logic                   preempt_o,
    output logic [CW-1:0]          hold_cnt_o
);

    localparam logic [GW-1:0] c_LAST_RST = GW'(NUM_MASTERS - 1);
    localparam logic [GW-1:0] c_CORE     = GW'(CORE_MASTER);
    localparam logic [CW-1:0] c_MAX      = CW'(MAX_HOLD);
    localparam logic [CW-1:0] c_TIMEOUT  = CW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    arb_state_t       r_state;
    logic [GW-1:0]    r_grant;
    logic             r_grant_valid;
    logic [GW-1:0]    r_last;
    logic [CW-1:0]    r_hold_cnt;
    logic             r_hold_flag;
    logic             r_preempt;

    arb_state_t       w_nxt_state;
    logic [GW-1:0]    w_nxt_grant;
    logic             w_nxt_valid;
    logic [GW-1:0]    w_nxt_last;
    logic [CW-1:0]    w_nxt_cnt;
    logic             w_nxt_flag;
    logic             w_nxt_preempt;

    logic             w_mask_en;
    logic [GW-1:0]    w_pick_idx;
    logic             w_pick_valid;
    logic [GW-1:0]    w_sel_idx;
    logic             w_dbg_take;
    logic             w_dbg_preempt;
    logic             w_own_req;
    logic             w_own_lock;
    logic             w_timeout;

    // While granted, the current owner is excluded so any valid pick means
    // "another master is waiting".
    assign w_mask_en  = (r_state == ARB_GRANT);
    assign w_own_req  = req_i[r_grant];
    assign w_own_lock = lock_i[r_grant];
    assign w_timeout  = (MAX_HOLD != 0) && (r_hold_cnt >= c_TIMEOUT);

    rib_rr_arbiter_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .GW          (GW)
    ) u_rr_pick (
        .i_req      (req_i),
        .i_last     (r_last),
        .i_mask_idx (r_grant),
        .i_mask_en  (w_mask_en),
        .o_idx      (w_pick_idx),
        .o_valid    (w_pick_valid)
    );

`ifdef RIB_ARB_DEBUG_PRIO_EN
    localparam logic [GW-1:0] c_DBG = GW'(NUM_MASTERS - 1);
    // Debug wins any arbitration point unless it already owns the bus.
    assign w_dbg_take    = req_i[NUM_MASTERS-1] && !(w_mask_en && (r_grant == c_DBG));
    assign w_dbg_preempt = w_dbg_take && w_mask_en;
    assign w_sel_idx     = w_dbg_take ? c_DBG : w_pick_idx;
`else
    assign w_dbg_take    = 1'b0;
    assign w_dbg_preempt = 1'b0;
    assign w_sel_idx     = w_pick_idx;
`endif

    // Next-state, grant, hold counter and stall flag decision
    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_grant   = r_grant;
        w_nxt_valid   = r_grant_valid;
        w_nxt_last    = r_last;
        w_nxt_cnt     = r_hold_cnt;
        w_nxt_preempt = 1'b0;
        w_nxt_flag    = 1'b0;

        case (r_state)
            ARB_IDLE: begin
                if (w_pick_valid) begin
                    w_nxt_state = ARB_GRANT;
                    w_nxt_grant = w_sel_idx;
                    w_nxt_valid = 1'b1;
                    w_nxt_last  = w_dbg_take ? r_last : w_sel_idx;
                    w_nxt_cnt   = '0;
                end
            end
            ARB_GRANT: begin
                if (!w_own_req) begin
                    // Owner released; a simultaneous timeout is a plain release
                    if (w_pick_valid) begin
                        w_nxt_grant = w_sel_idx;
                        w_nxt_last  = w_dbg_take ? r_last : w_sel_idx;
                    end else begin
                        w_nxt_state = ARB_IDLE;
                        w_nxt_valid = 1'b0;
                    end
                    w_nxt_cnt = '0;
                end else if (w_pick_valid) begin
                    if (!w_own_lock && (w_timeout || w_dbg_preempt)) begin
                        w_nxt_grant   = w_sel_idx;
                        w_nxt_last    = w_dbg_take ? r_last : w_sel_idx;
                        w_nxt_cnt     = '0;
                        w_nxt_preempt = 1'b1;
                    end else if (r_hold_cnt != c_MAX) begin
                        w_nxt_cnt = r_hold_cnt + CW'(1);
                    end
                end else begin
                    w_nxt_cnt = '0;
                end
            end
            default: begin
                w_nxt_state = ARB_IDLE;
                w_nxt_valid = 1'b0;
            end
        endcase

        // Stall the core when someone else owns the bus or it waits for it
        w_nxt_flag = (w_nxt_valid && (w_nxt_grant != c_CORE)) ||
                     (req_i[CORE_MASTER] && !(w_nxt_valid && (w_nxt_grant == c_CORE)));
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ARB_IDLE;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_last        <= c_LAST_RST;
            r_hold_cnt    <= '0;
            r_hold_flag   <= 1'b0;
            r_preempt     <= 1'b0;
        end else begin
            r_state       <= w_nxt_state;
            r_grant       <= w_nxt_grant;
            r_grant_valid <= w_nxt_valid;
            r_last        <= w_nxt_last;
            r_hold_cnt    <= w_nxt_cnt;
            r_hold_flag   <= w_nxt_flag;
            r_preempt     <= w_nxt_preempt;
        end
    end

    assign grant_o       = r_grant;
    assign grant_valid_o = r_grant_valid;
    assign hold_flag_o   = r_hold_flag;
    assign preempt_o     = r_preempt;
    assign hold_cnt_o    = r_hold_cnt;

endmodule : rib_rr_arbiter
`default_nettype wire
